// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: captures one 128-bit block, inverse-S-boxes
// BYTES_PER_CYCLE bytes per cycle in place, then holds the result until taken.
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int NCYC    = 16 / BYTES_PER_CYCLE;
  localparam int CW      = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
  localparam logic [CW-1:0] LAST_K = CW'(NCYC - 1);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_illegal_bpc
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Handshake: a block moves on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE, out_valid only in DONE; out_data is held
  // stable for as long as out_valid is high and out_ready is low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          fsm_q, fsm_d;
  logic [127:0]    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [CHUNK_W-1:0] chunk_in, chunk_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ ({8{aa[7]}} & 8'h1b);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(inv_affine(x));
  endfunction

  always_comb begin
    chunk_in  = state_q[int'(cnt_q) * CHUNK_W +: CHUNK_W];
    chunk_out = '0;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      chunk_out[8*j +: 8] = inv_sbox(chunk_in[8*j +: 8]);
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = in_data;
          cnt_d      = '0;
          fsm_d      = BUSY;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      BUSY: begin
        state_d[int'(cnt_q) * CHUNK_W +: CHUNK_W] = chunk_out;
        // Wrap explicitly so the chunk select never points past the block.
        cnt_d = (cnt_q == LAST_K) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST_K) begin
          fsm_d       = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        fsm_d       = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = state_q;
  assign dbg_state = fsm_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: directed cases plus 1000 random blocks checked
// through an expected-block queue against a table built from the forward S-box.
module tb_inv_sub_bytes_iter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // ---------------- DUT instances ----------------
  logic [127:0] in_data_4, out_data_4;
  logic in_valid_4, in_ready_4, out_valid_4, out_ready_4, busy_4;
  logic [1:0] dbg_4;
  logic [127:0] in_data_1, out_data_1;
  logic in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
  logic [1:0] dbg_1;
  logic [127:0] in_data_16, out_data_16;
  logic in_valid_16, in_ready_16, out_valid_16, out_ready_16, busy_16;
  logic [1:0] dbg_16;

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_4), .in_valid(in_valid_4),
    .in_ready(in_ready_4), .out_data(out_data_4), .out_valid(out_valid_4),
    .out_ready(out_ready_4), .busy(busy_4), .dbg_state(dbg_4));

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_1), .in_valid(in_valid_1),
    .in_ready(in_ready_1), .out_data(out_data_1), .out_valid(out_valid_1),
    .out_ready(out_ready_1), .busy(busy_1), .dbg_state(dbg_1));

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_16), .in_valid(in_valid_16),
    .in_ready(in_ready_16), .out_data(out_data_16), .out_valid(out_valid_16),
    .out_ready(out_ready_16), .busy(busy_16), .dbg_state(dbg_16));

  // ---------------- reference model ----------------
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] tb_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] tb_gf_inv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) if (tb_gf_mul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Build the forward S-box and store it inverted.
  task automatic build_table();
    logic [7:0] v, s;
    for (int x = 0; x < 256; x++) begin
      v = tb_gf_inv(8'(x));
      s = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [127:0] exp_q[$];
  int n_acc = 0;
  int n_out = 0;
  int last_acc = 0;
  bit have_last = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      have_last = 0;
    end else begin
      if (in_valid_4 && in_ready_4) begin
        exp_q.push_back(ref_block(in_data_4));
        n_acc++;
        if (have_last) begin
          n_checks++;
          if (cycle - last_acc >= 6) n_pass++;
          else $display("FAIL block_spacing: actual %0d cycles required at least 6", cycle - last_acc);
        end
        last_acc = cycle;
        have_last = 1;
      end
      if (out_valid_4 && out_ready_4) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: actual %h required no output", out_data_4);
        end else begin
          check("block_data", out_data_4, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send4(input logic [127:0] d);
    int t;
    t = 0;
    in_data_4  = d;
    in_valid_4 = 1'b1;
    @(negedge clk);
    while (!in_ready_4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_4) begin
      n_checks++;
      $display("FAIL send_timeout: actual in_ready 0 required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid_4 = 1'b0;
    in_data_4  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_out4(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid_4) break;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int acc0, out0, t;
    logic [127:0] r, e;
    bit rand_done;

    build_table();
    rst_n = 1'b0;
    in_valid_4 = 0;  in_data_4 = '0;  out_ready_4 = 1;
    in_valid_1 = 0;  in_data_1 = '0;  out_ready_1 = 1;
    in_valid_16 = 0; in_data_16 = '0; out_ready_16 = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_in_ready", 128'(in_ready_4), 128'd1);
    check("rst_out_valid", 128'(out_valid_4), 128'd0);
    check("rst_busy", 128'(busy_4), 128'd0);
    check("rst_out_data", out_data_4, 128'h0);

    // all-zero block
    send4(128'h0);
    check("busy_after_accept", 128'(busy_4), 128'd1);
    check("in_ready_after_accept", 128'(in_ready_4), 128'd0);
    wait_out4(lat);
    check("latency_zero", 128'(lat), 128'd4);
    check("data_zero", out_data_4, 128'h52525252_52525252_52525252_52525252);
    @(posedge clk); #1;
    check("idle_after_xfer_ready", 128'(in_ready_4), 128'd1);
    check("idle_after_xfer_valid", 128'(out_valid_4), 128'd0);

    // ascending byte pattern
    send4(128'h0f0e0d0c_0b0a0908_07060504_03020100);
    wait_out4(lat);
    check("latency_ascend", 128'(lat), 128'd4);
    check("data_ascend", out_data_4, 128'hfbd7f381_9ea340bf_38a53630_d56a0952);
    @(posedge clk); #1;

    // output stall with a competing input offered
    out_ready_4 = 1'b0;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    e = ref_block(r);
    send4(r);
    wait_out4(lat);
    in_data_4  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid_4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 128'(out_valid_4), 128'd1);
      check("stall_data", out_data_4, e);
      check("stall_in_ready", 128'(in_ready_4), 128'd0);
      @(posedge clk); #1;
    end
    in_valid_4  = 1'b0;
    out_ready_4 = 1'b1;
    @(posedge clk); #1;
    check("stall_release_ready", 128'(in_ready_4), 128'd1);
    check("stall_release_valid", 128'(out_valid_4), 128'd0);

    // reset while the counter holds 2
    send4({$urandom(), $urandom(), $urandom(), $urandom()});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_reset", 128'(busy_4), 128'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 128'(in_ready_4), 128'd1);
    check("midrst_busy", 128'(busy_4), 128'd0);
    check("midrst_out_valid", 128'(out_valid_4), 128'd0);
    check("midrst_out_data", out_data_4, 128'h0);
    out0 = n_out;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_output", 128'(n_out), 128'(out0));

    // random traffic
    acc0 = n_acc;
    out0 = n_out;
    rand_done = 0;
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          send4({$urandom(), $urandom(), $urandom(), $urandom()});
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready_4 = ($urandom_range(0, 3) != 0);
        end
        out_ready_4 = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
    check("random_accepted", 128'(n_acc - acc0), 128'd1000);
    check("random_delivered", 128'(n_out - out0), 128'd1000);

    // one byte per cycle
    check("u1_ready", 128'(in_ready_1), 128'd1);
    in_data_1  = {16{8'h63}};
    in_valid_1 = 1'b1;
    @(posedge clk); #1;
    in_valid_1 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid_1) break;
    end
    check("u1_latency", 128'(lat), 128'd16);
    check("u1_data", out_data_1, 128'h0);
    @(posedge clk); #1;
    check("u1_idle", 128'(in_ready_1), 128'd1);

    // whole block in one cycle
    check("u16_ready", 128'(in_ready_16), 128'd1);
    in_data_16  = {16{8'h7c}};
    in_valid_16 = 1'b1;
    @(posedge clk); #1;
    in_valid_16 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid_16) break;
    end
    check("u16_latency", 128'(lat), 128'd1);
    check("u16_data", out_data_16, {16{8'h01}});
    @(posedge clk); #1;
    check("u16_idle", 128'(in_ready_16), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual time limit reached required finish before it");
    $fatal(1, "watchdog expired");
  end

endmodule
